// File: rtl/threshold_bank_if.sv
// threshold_bank_if: button inputs and threshold/selection outputs
// of the threshold register bank.
interface threshold_bank_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8
);
  localparam int SW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                    increment;
  logic                    decrement;
  logic                    select;
  logic [NUM_CH*WIDTH-1:0] thresholds_out;
  logic [SW-1:0]           sel_out;
  logic [WIDTH-1:0]        sel_value_out;
  logic                    changed_out;

  modport master (
    output increment,
    output decrement,
    output select,
    input  thresholds_out,
    input  sel_out,
    input  sel_value_out,
    input  changed_out
  );

  modport slave (
    input  increment,
    input  decrement,
    input  select,
    output thresholds_out,
    output sel_out,
    output sel_value_out,
    output changed_out
  );
endinterface

// File: rtl/threshold_bank.sv
// threshold_bank: button-driven saturating multi-channel threshold bank.
// Auto-repeat on held buttons is compiled in by THRESHOLD_AUTO_REPEAT_EN.
module debouncer #(
  parameter int CYCLES = 1_000_000
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic dirty_in,
  output logic clean_out
);
  localparam int CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [CW-1:0] cnt;

  // Output follows the input only after it has differed for CYCLES edges.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt       <= '0;
      clean_out <= 1'b0;
    end else if (dirty_in == clean_out) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt       <= '0;
      clean_out <= dirty_in;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

module threshold_bank #(
  parameter int NUM_CH          = 4,
  parameter int WIDTH           = 8,
  parameter int STEP            = 10,
  parameter int MIN_VAL         = 0,
  parameter int MAX_VAL         = 250,
  parameter int RESET_VAL       = 128,
  parameter int HOLD_CYCLES     = 50_000_000,
  parameter int REPEAT_CYCLES   = 10_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input logic           clk_in,
  input logic           rst_n_in,
  threshold_bank_if.slave bus
);
  localparam int SW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int VW = WIDTH + 1;
  localparam logic [VW-1:0]    STEP_V  = VW'(STEP);
  localparam logic [VW-1:0]    MIN_V   = VW'(MIN_VAL);
  localparam logic [VW-1:0]    MAX_V   = VW'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_V   = WIDTH'(RESET_VAL);
  localparam logic [SW-1:0]    LAST_CH = SW'(NUM_CH - 1);

  logic [2:0]       raw;
  logic [2:0]       clean;
  logic [2:0]       btn_q;
  logic [2:0]       btn_qq;
  logic [2:0]       btn_p;
  logic             inc_p;
  logic             dec_p;
  logic             sel_p;
  logic [1:0]       rpt_tick;
  logic             up_ev;
  logic             dn_ev;
  logic [WIDTH-1:0] vals [NUM_CH];
  logic [SW-1:0]    sel;
  logic [VW-1:0]    cur;
  logic [VW-1:0]    nxt;
  logic             wr;
  logic             changed;

  assign raw = {bus.select, bus.decrement, bus.increment};

  for (genvar i = 0; i < 3; i++) begin : g_db
    debouncer #(
      .CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk_in   (clk_in),
      .rst_in   (~rst_n_in),
      .dirty_in (raw[i]),
      .clean_out(clean[i])
    );
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      btn_q  <= '0;
      btn_qq <= '0;
      btn_p  <= '0;
    end else begin
      btn_q  <= clean;
      btn_qq <= btn_q;
      btn_p  <= btn_q & ~btn_qq;
    end
  end

  assign inc_p = btn_p[0];
  assign dec_p = btn_p[1];
  assign sel_p = btn_p[2];

`ifdef THRESHOLD_AUTO_REPEAT_EN
  localparam int CMAX = (HOLD_CYCLES > REPEAT_CYCLES) ?
                        HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] HOLD_V = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] RPT_V  = CW'(REPEAT_CYCLES);

  logic [CW-1:0] rpt_cnt;
  logic [CW-1:0] rpt_lim;
  logic          rpt_phase;
  logic          one_held;

  assign one_held = btn_q[0] ^ btn_q[1];
  assign rpt_lim  = rpt_phase ? RPT_V : HOLD_V;

  // Count 1 lands on the edge the initial pulse is registered,
  // so a tick lines up with the step pipeline of a real press.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      rpt_cnt   <= '0;
      rpt_phase <= 1'b0;
      rpt_tick  <= '0;
    end else begin
      rpt_tick <= '0;
      if (!one_held || sel_p) begin
        rpt_cnt   <= '0;
        rpt_phase <= 1'b0;
      end else if (rpt_cnt == rpt_lim) begin
        rpt_cnt   <= CW'(1);
        rpt_phase <= 1'b1;
        rpt_tick  <= btn_q[1:0];
      end else begin
        rpt_cnt <= rpt_cnt + 1'b1;
      end
    end
  end
`else
  assign rpt_tick = 2'b00;
`endif

  assign up_ev = inc_p | rpt_tick[0];
  assign dn_ev = dec_p | rpt_tick[1];
  assign cur   = {1'b0, vals[sel]};

  always_comb begin
    nxt = cur;
    unique case (1'b1)
      up_ev & ~dn_ev:
        nxt = (cur + STEP_V > MAX_V) ? MAX_V : cur + STEP_V;
      dn_ev & ~up_ev:
        nxt = (cur < MIN_V + STEP_V) ? MIN_V : cur - STEP_V;
      default:
        nxt = cur;
    endcase
  end

  assign wr = (nxt != cur);

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      for (int k = 0; k < NUM_CH; k++) begin
        vals[k] <= RST_V;
      end
      sel     <= '0;
      changed <= 1'b0;
    end else begin
      if (wr) begin
        vals[sel] <= nxt[WIDTH-1:0];
      end
      if (sel_p) begin
        sel <= (sel == LAST_CH) ? '0 : sel + 1'b1;
      end
      changed <= wr;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_out
    assign bus.thresholds_out[k*WIDTH +: WIDTH] = vals[k];
  end

  assign bus.sel_out       = sel;
  assign bus.sel_value_out = vals[sel];
  assign bus.changed_out   = changed;
endmodule

// File: tb/tb_threshold_bank.sv
// tb_threshold_bank: random and directed button sequences against a
// value-level model of the threshold bank.
module tb_threshold_bank;
  localparam int NUM_CH = 4;
  localparam int WIDTH  = 8;
  localparam int STEP   = 10;
  localparam int MINV   = 0;
  localparam int MAXV   = 250;
  localparam int RSTV   = 128;
  localparam int HOLD   = 100;
  localparam int REP    = 20;
  localparam int DEB    = 1;

  logic clk_in = 1'b0;
  logic rst_n_in;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   mv [NUM_CH];
  int   msel;

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  threshold_bank_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) bus ();

  threshold_bank #(
    .NUM_CH(NUM_CH), .WIDTH(WIDTH), .STEP(STEP),
    .MIN_VAL(MINV), .MAX_VAL(MAXV), .RESET_VAL(RSTV),
    .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .bus     (bus)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int step_to(int v, bit up);
    if (up) return (v + STEP > MAXV) ? MAXV : v + STEP;
    return (v - STEP < MINV) ? MINV : v - STEP;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NUM_CH; k++) mv[k] = RSTV;
    msel = 0;
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < NUM_CH; k++)
      chk($sformatf("%s ch%0d", tag, k),
          64'(bus.thresholds_out[k*WIDTH +: WIDTH]), 64'(mv[k]));
    chk({tag, " sel"}, 64'(bus.sel_out), 64'(msel));
    chk({tag, " selval"}, 64'(bus.sel_value_out), 64'(mv[msel]));
  endtask

  task automatic do_reset();
    rst_n_in      = 1'b0;
    bus.increment = 1'b0;
    bus.decrement = 1'b0;
    bus.select    = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    model_reset();
  endtask

  task automatic press(input bit i, input bit d, input bit s,
                       input int hold, input string tag);
    int n = 0;
    int old;
    int exp = 0;
    bus.increment = i;
    bus.decrement = d;
    bus.select    = s;
    repeat (hold) begin
      @(negedge clk_in);
      if (bus.changed_out) n++;
    end
    bus.increment = 1'b0;
    bus.decrement = 1'b0;
    bus.select    = 1'b0;
    repeat (8) begin
      @(negedge clk_in);
      if (bus.changed_out) n++;
    end
    if (i != d) begin
      old = mv[msel];
      mv[msel] = step_to(old, i);
      exp = (mv[msel] != old) ? 1 : 0;
    end
    if (s) msel = (msel + 1) % NUM_CH;
    chk({tag, " pulses"}, 64'(n), 64'(exp));
    check_all(tag);
  endtask

  // Hold increment on channel 0; rel 0 is the edge of the first step.
  task automatic hold_run(input int hold_after, input bit rst_mid);
    int q[$];
    int eq[$];
    int rel;
    int base;
    int n = 0;
    int v = RSTV;
    eq.push_back(0);
`ifdef THRESHOLD_AUTO_REPEAT_EN
    for (int t = HOLD; t <= hold_after; t += REP) eq.push_back(t);
`endif
    foreach (eq[k]) v = step_to(v, 1'b1);
    bus.increment = 1'b1;
    base = cyc;
    do begin
      @(negedge clk_in);
      rel = cyc - base - 4;
      if (bus.changed_out) q.push_back(rel);
    end while (rel < hold_after);
    if (rst_mid) begin
      chk("pre-reset ch0", 64'(bus.thresholds_out[WIDTH-1:0]), 64'(v));
      rst_n_in = 1'b0;
    end
    bus.increment = 1'b0;
    if (rst_mid) begin
      repeat (2) @(negedge clk_in);
      rst_n_in = 1'b1;
      model_reset();
      repeat (40) begin
        @(negedge clk_in);
        if (bus.changed_out) n++;
      end
      chk("post-reset pulses", 64'(n), 64'(0));
      check_all("post-reset");
    end else begin
      repeat (10) begin
        @(negedge clk_in);
        if (bus.changed_out) q.push_back(cyc - base - 4);
      end
      mv[0] = v;
      check_all("repeat");
    end
    chk("repeat count", 64'(q.size()), 64'(eq.size()));
    for (int k = 0; k < q.size() && k < eq.size(); k++)
      chk($sformatf("repeat step%0d", k), 64'(q[k]), 64'(eq[k]));
  endtask

  initial begin
    do_reset();
    check_all("reset");
    chk("reset changed", 64'(bus.changed_out), 64'(0));

    // Exact latency of a single press on channel 0.
    bus.increment = 1'b1;
    repeat (3) @(negedge clk_in);
    chk("lat pre ch0", 64'(bus.thresholds_out[WIDTH-1:0]), 64'(RSTV));
    chk("lat pre chg", 64'(bus.changed_out), 64'(0));
    @(negedge clk_in);
    chk("lat ch0", 64'(bus.thresholds_out[WIDTH-1:0]), 64'(RSTV + STEP));
    chk("lat chg", 64'(bus.changed_out), 64'(1));
    @(negedge clk_in);
    chk("lat chg drop", 64'(bus.changed_out), 64'(0));
    bus.increment = 1'b0;
    repeat (8) @(negedge clk_in);
    mv[0] = RSTV + STEP;
    check_all("single");

    // Saturation: up to 248, then clamp at 250.
    for (int k = 0; k < 13; k++) press(1, 0, 0, 3, "sat up");
    press(1, 0, 0, 3, "sat up hold");
    press(0, 0, 1, 3, "to ch1");
    for (int k = 0; k < 13; k++) press(0, 1, 0, 3, "sat dn");
    press(0, 1, 0, 3, "sat dn hold");

    do_reset();
    for (int k = 0; k < 4; k++) press(0, 0, 1, 2, "sel");
    press(0, 0, 1, 2, "sel");
    press(0, 0, 1, 2, "sel");
    press(1, 0, 0, 2, "sel inc");

    press(1, 1, 0, 130, "conflict");

    do_reset();
    hold_run(145, 1'b0);
    do_reset();
    hold_run(130, 1'b1);

    do_reset();
    for (int n = 0; n < 40; n++) begin
      bit i = 1'b0;
      bit d = 1'b0;
      bit s = 1'b0;
      case ($urandom_range(0, 7))
        0, 1: i = 1'b1;
        2, 3: d = 1'b1;
        4: s = 1'b1;
        5: begin i = 1'b1; s = 1'b1; end
        6: begin d = 1'b1; s = 1'b1; end
        default: begin i = 1'b1; d = 1'b1; end
      endcase
      press(i, d, s, int'($urandom_range(2, 8)), "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
